// File: rtl/softreg_mux_n_pkg.sv
// Shared types and constants for the N-source soft-register combiner.
package softreg_mux_n_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int SR_ADDR_W = 32;
  localparam int SR_DATA_W = 64;

  // Source identifier, wide enough for the largest supported source count (8).
  typedef logic [2:0] SoftRegSrcId;

  typedef struct packed {
    logic                 valid;
    logic                 isWrite;
    logic [SR_ADDR_W-1:0] addr;
    logic [SR_DATA_W-1:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic                 valid;
    logic [SR_DATA_W-1:0] data;
  } SoftRegResp;

  localparam int REQ_W  = $bits(SoftRegReq);
  localparam int RESP_W = $bits(SoftRegResp);

  // Width of a source index; never narrower than one bit.
  function automatic int src_id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softreg_rr_arbiter.sv
// One-hot arbiter over the eligible sources: fixed priority or round-robin.
module softreg_rr_arbiter
  import softreg_mux_n_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int SRC_W   = src_id_width(NUM_SRC)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_elig,
  output logic [NUM_SRC-1:0] o_grant,
  output logic [SRC_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  logic [SRC_W-1:0]   r_ptr;
  logic [NUM_SRC-1:0] w_upper;
  logic [NUM_SRC-1:0] w_pool;

  // Round-robin: prefer sources above the pointer, else wrap to the lowest.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_upper[i] = i_elig[i] && (SRC_W'(i) > r_ptr);
    end
    if ((ARB_MODE == ARB_RR) && (|w_upper)) begin
      w_pool = w_upper;
    end else begin
      w_pool = i_elig;
    end
  end

  // Lowest set bit of the candidate pool wins.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pool[i] && !o_grant_valid) begin
        o_grant[i]    = 1'b1;
        o_grant_idx   = SRC_W'(i);
        o_grant_valid = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; reset value makes source 0 win first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= SRC_W'(NUM_SRC - 1);
    end else if (o_grant_valid) begin
      r_ptr <= o_grant_idx;
    end
  end

endmodule

// File: rtl/softreg_mux_n.sv
// N-source soft-register combiner: per-source queues, one issue per cycle,
// read tags tracked in issue order so responses return to their issuer.
module softreg_mux_n
  import softreg_mux_n_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int LOG_DEPTH = 4,
  parameter int ARB_MODE  = ARB_FIXED,
  parameter int LOG_OUTST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*REQ_W-1:0]  i_req_in,
  output logic [REQ_W-1:0]          o_req_to_app,
  input  logic [RESP_W-1:0]         i_resp_from_app,
  output logic [NUM_SRC*RESP_W-1:0] o_resp_out,
  output logic [NUM_SRC-1:0]        o_src_full,
  output logic [NUM_SRC*16-1:0]     o_drop_cnt,
  output logic                      o_spurious_err
);

  localparam int SRC_W     = src_id_width(NUM_SRC);
  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int TAG_DEPTH = 1 << LOG_OUTST;
  localparam int ENT_W     = REQ_W - 1;   // queued entry drops the valid bit

  logic [NUM_SRC-1:0]            w_q_full;
  logic [NUM_SRC-1:0]            w_q_empty;
  logic [NUM_SRC-1:0]            w_q_head_wr;
  logic [NUM_SRC-1:0]            w_elig;
  logic [NUM_SRC-1:0]            w_grant;
  logic [NUM_SRC-1:0][ENT_W-1:0] w_q_head;
  logic [SRC_W-1:0]              w_gidx;
  logic                          w_gvalid;

  SoftRegResp  w_resp_in;
  SoftRegReq   w_issue;
  SoftRegReq   r_req;
  logic        w_tag_full;
  logic        w_tag_empty;
  logic        w_tag_push;
  logic        w_tag_pop;
  SoftRegSrcId w_tag_head;
  logic        r_spurious;

  SoftRegSrcId            r_tag_mem [TAG_DEPTH];
  logic [LOG_OUTST-1:0]   r_tag_wr;
  logic [LOG_OUTST-1:0]   r_tag_rd;
  logic [LOG_OUTST:0]     r_tag_cnt;

  assign w_resp_in = i_resp_from_app;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    SoftRegReq            w_req;
    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_cnt;
    logic                 w_push;
    logic                 w_pop;
    logic [15:0]          r_drop;
    SoftRegResp           r_resp;

    assign w_req           = i_req_in[gi*REQ_W +: REQ_W];
    assign w_q_full[gi]    = (r_cnt == (LOG_DEPTH+1)'(DEPTH));
    assign w_q_empty[gi]   = (r_cnt == '0);
    assign w_push          = w_req.valid && !w_q_full[gi];
    assign w_pop           = w_grant[gi];
    // Head read is combinational so a request can issue the cycle after it lands.
    assign w_q_head[gi]    = r_mem[r_rd_ptr];
    assign w_q_head_wr[gi] = w_q_head[gi][ENT_W-1];
    // A read head waits for a free tag slot; a write head never does.
    assign w_elig[gi]      = !w_q_empty[gi] && (w_q_head_wr[gi] || !w_tag_full);

    // Queue storage; contents are don't-care while the queue is empty.
    always_ff @(posedge i_clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_req[ENT_W-1:0];
      end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
        else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
    end

    // Saturating count of requests refused because the queue was full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_drop <= '0;
      end else if (w_req.valid && w_q_full[gi] && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end

    // Route a tagged response to this source; otherwise drive all-zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_resp <= '0;
      end else if (w_tag_pop && (w_tag_head == SoftRegSrcId'(gi))) begin
        r_resp <= w_resp_in;
      end else begin
        r_resp <= '0;
      end
    end

    assign o_resp_out[gi*RESP_W +: RESP_W] = r_resp;
    assign o_drop_cnt[gi*16 +: 16]         = r_drop;
    assign o_src_full[gi]                  = w_q_full[gi];
  end

  softreg_rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_elig        (w_elig),
    .o_grant       (w_grant),
    .o_grant_idx   (w_gidx),
    .o_grant_valid (w_gvalid)
  );

  // Build the outgoing request from the granted head; all-zero when idle.
  always_comb begin
    w_issue = '0;
    if (w_gvalid) begin
      w_issue.valid = 1'b1;
      {w_issue.isWrite, w_issue.addr, w_issue.data} = w_q_head[w_gidx];
    end
  end

  // Registered request to the app.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req <= '0;
    end else begin
      r_req <= w_issue;
    end
  end

  assign o_req_to_app = r_req;

  assign w_tag_full  = (r_tag_cnt == (LOG_OUTST+1)'(TAG_DEPTH));
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_push  = w_gvalid && !w_q_head_wr[w_gidx];
  assign w_tag_pop   = w_resp_in.valid && !w_tag_empty;
  assign w_tag_head  = r_tag_mem[r_tag_rd];

  // Tag storage: source index of each read, in issue order.
  always_ff @(posedge i_clk) begin
    if (w_tag_push) begin
      r_tag_mem[r_tag_wr] <= SoftRegSrcId'(w_gidx);
    end
  end

  // Tag pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_tag_push) r_tag_wr <= r_tag_wr + 1'b1;
      if (w_tag_pop)  r_tag_rd <= r_tag_rd + 1'b1;
      if (w_tag_push && !w_tag_pop)      r_tag_cnt <= r_tag_cnt + 1'b1;
      else if (!w_tag_push && w_tag_pop) r_tag_cnt <= r_tag_cnt - 1'b1;
    end
  end

  // Sticky flag for a response that no outstanding read accounts for.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spurious <= 1'b0;
    end else if (w_resp_in.valid && w_tag_empty) begin
      r_spurious <= 1'b1;
    end
  end

  assign o_spurious_err = r_spurious;

endmodule

// File: tb/tb_softreg_mux_n.sv
// Scoreboard bench for softreg_mux_n: 3 sources, round-robin, depth-4 queues,
// two reads outstanding at most.
module tb_softreg_mux_n;
  import softreg_mux_n_pkg::*;

  localparam int N = 3;
  typedef logic [127:0] val_t;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  SoftRegReq             req_a [N];
  logic [N*REQ_W-1:0]    req_in;
  logic [REQ_W-1:0]      req_to_app;
  SoftRegResp            resp_app;
  logic [N*RESP_W-1:0]   resp_out;
  logic [N-1:0]          src_full;
  logic [N*16-1:0]       drop_cnt;
  logic                  spurious;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b1;
  int   issue_cnt = 0;
  int   issue_cyc [$];
  SoftRegReq exp_req [$];
  val_t      exp_resp [$];

  softreg_mux_n #(
    .NUM_SRC   (N),
    .LOG_DEPTH (2),
    .ARB_MODE  (ARB_RR),
    .LOG_OUTST (1)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_in        (req_in),
    .o_req_to_app    (req_to_app),
    .i_resp_from_app (resp_app),
    .o_resp_out      (resp_out),
    .o_src_full      (src_full),
    .o_drop_cnt      (drop_cnt),
    .o_spurious_err  (spurious)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_in = '0;
    for (int i = 0; i < N; i++) req_in[i*REQ_W +: REQ_W] = req_a[i];
  end

  task automatic check_eq(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: compare every issued request and routed response with the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      SoftRegReq  got;
      SoftRegResp r;
      got = req_to_app;
      if (got.valid) begin
        issue_cnt++;
        issue_cyc.push_back(cyc);
        $display("req  wr=%0d addr=%h data=%h", got.isWrite, got.addr, got.data);
        if (exp_req.size() > 0) check_eq("req", val_t'(got), val_t'(exp_req.pop_front()));
        else check_eq("req_unexpected", val_t'(got), '0);
      end
      for (int i = 0; i < N; i++) begin
        r = resp_out[i*RESP_W +: RESP_W];
        if (r.valid) begin
          $display("resp src=%0d data=%h", i, r.data);
          if (exp_resp.size() > 0) check_eq("resp", val_t'({8'(i), r}), exp_resp.pop_front());
          else check_eq("resp_unexpected", val_t'({8'(i), r}), '0);
        end
      end
    end
  end

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) req_a[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_reqs();
    resp_app = '0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic put(input int s, input bit wr, input logic [31:0] a,
                     input logic [63:0] d, input bit expect_issue);
    req_a[s] = '{valid: 1'b1, isWrite: wr, addr: a, data: d};
    if (expect_issue) exp_req.push_back(req_a[s]);
  endtask

  task automatic app_resp(input logic [63:0] d, input int src);
    resp_app.valid = 1'b1;
    resp_app.data  = d;
    exp_resp.push_back(val_t'({8'(src), 1'b1, d}));
    steps(3);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req"},  val_t'(req_to_app), '0);
    check_eq({tag, "_resp"}, val_t'(resp_out), '0);
    check_eq({tag, "_drop"}, val_t'(drop_cnt), '0);
    check_eq({tag, "_full"}, val_t'(src_full), '0);
    check_eq({tag, "_spur"}, val_t'(spurious), '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_req.delete();
    exp_resp.delete();
    clear_reqs();
    resp_app = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    clear_reqs();
    resp_app = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("reset");

    // Both sources write in one cycle: 0x10 then 0x20 on consecutive cycles.
    issue_cyc.delete();
    c0 = cyc;
    put(0, 1'b1, 32'h10, 64'h1111_0000_0000_0010, 1'b1);
    put(1, 1'b1, 32'h20, 64'h2222_0000_0000_0020, 1'b1);
    step();
    steps(4);
    check_eq("t1_drain", exp_req.size(), 0);
    check_eq("t1_issues", issue_cyc.size(), 2);
    if (issue_cyc.size() >= 2) begin
      check_eq("t1_lat_first", issue_cyc[0], c0 + 2);
      check_eq("t1_lat_second", issue_cyc[1], c0 + 3);
    end
    check_eq("t1_drop", val_t'(drop_cnt), '0);

    // Round-robin from reset over two writes per source: 0,1,2,0,1,2.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < N; s++) begin
        put(s, 1'b1, 32'h40 + 32'(s*4 + k*16), 64'($urandom), 1'b1);
      end
      step();
    end
    steps(8);
    check_eq("t2_drain", exp_req.size(), 0);

    // Read routing in issue order.
    put(1, 1'b0, 32'h8, 64'h0, 1'b1);
    step();
    put(0, 1'b0, 32'hC, 64'h0, 1'b1);
    step();
    steps(4);
    check_eq("t3_reqs", exp_req.size(), 0);
    app_resp(64'hAAAA, 1);
    app_resp(64'hBBBB, 0);
    check_eq("t3_resps", exp_resp.size(), 0);

    // Tag FIFO full: third read held, write from another source still flows.
    base = issue_cnt;
    put(0, 1'b0, 32'h100, 64'h0, 1'b1);
    step();
    put(0, 1'b0, 32'h104, 64'h0, 1'b1);
    step();
    steps(3);
    put(1, 1'b1, 32'h200, 64'hCAFE, 1'b1);
    put(0, 1'b0, 32'h108, 64'h0, 1'b1);
    step();
    steps(5);
    check_eq("t5_held", issue_cnt - base, 3);
    app_resp(64'h1111, 0);
    steps(2);
    check_eq("t5_released", issue_cnt - base, 4);
    app_resp(64'h2222, 0);
    app_resp(64'h3333, 0);
    check_eq("t5_resps", exp_resp.size(), 0);

    // Overflow: src1 fills the tag FIFO, src0 bursts six reads into a depth-4 queue.
    put(1, 1'b0, 32'h300, 64'h0, 1'b1);
    step();
    put(1, 1'b0, 32'h304, 64'h0, 1'b1);
    step();
    steps(3);
    for (int j = 0; j < 6; j++) begin
      put(0, 1'b0, 32'h400 + 32'(j*4), 64'h0, (j < 4));
      step();
    end
    steps(2);
    check_eq("t4_full0", val_t'(src_full[0]), 1);
    check_eq("t4_drop0", val_t'(drop_cnt[0 +: 16]), 2);
    check_eq("t4_drop1", val_t'(drop_cnt[16 +: 16]), 0);
    app_resp(64'h3000, 1);
    app_resp(64'h3004, 1);
    for (int j = 0; j < 4; j++) app_resp(64'h4000 + 64'(j), 0);
    check_eq("t4_reqs", exp_req.size(), 0);
    check_eq("t4_resps", exp_resp.size(), 0);
    check_eq("t4_full_after", val_t'(src_full), 0);

    // Response with nothing outstanding.
    resp_app.valid = 1'b1;
    resp_app.data  = 64'h5555;
    step();
    check_eq("t6_spur", val_t'(spurious), 1);
    check_eq("t6_resp_zero", val_t'(resp_out), '0);
    steps(3);
    check_eq("t6_spur_sticky", val_t'(spurious), 1);

    // Leave a read outstanding, then reset mid-burst.
    put(2, 1'b0, 32'h500, 64'h0, 1'b1);
    step();
    steps(3);
    check_eq("t6_read_out", exp_req.size(), 0);
    mon_en = 1'b0;
    for (int s = 0; s < N; s++) put(s, 1'b1, 32'h600 + 32'(s), 64'h0, 1'b0);
    step();
    for (int s = 0; s < N; s++) put(s, 1'b1, 32'h700 + 32'(s), 64'h0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("t6_async");
    do_reset();
    mon_en = 1'b1;
    step();
    // The pre-reset read's answer now has no tag behind it.
    resp_app.valid = 1'b1;
    resp_app.data  = 64'h6666;
    step();
    check_eq("t6_orphan_spur", val_t'(spurious), 1);
    check_eq("t6_orphan_resp", val_t'(resp_out), '0);
    steps(2);

    check_eq("final_req_q", exp_req.size(), 0);
    check_eq("final_resp_q", exp_resp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
